// File: rtl/prio_req_queue.sv
// Request-capture stage: rising-edge detection on four request lines, saturating
// per-line pending counters, priority presentation (i3 highest). Optional masking via PRQ_MASK_EN.
module prio_req_queue #(
  parameter int unsigned CNT_W = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i0,
  input  logic       i1,
  input  logic       i2,
  input  logic       i3,
  input  logic       ack,
`ifdef PRQ_MASK_EN
  input  logic       mask_we,
  input  logic [3:0] mask_in,
`endif
  output logic       valid,
  output logic       y0,
  output logic       y1,
  output logic [3:0] pend,
  output logic [3:0] ovf
);

  localparam logic [CNT_W-1:0] CMAX = '1;

  logic [3:0]       in_q;
  logic [CNT_W-1:0] cnt [4];
  logic [3:0]       mask;
  logic [3:0]       rise;
  logic [3:0]       dec;
  logic [3:0]       eligible;
  logic [1:0]       sel;

`ifdef PRQ_MASK_EN
  always_ff @(posedge clk) begin
    if (rst)
      mask <= '0;
    else if (mask_we)
      mask <= mask_in;
  end
`else
  assign mask = '0;
`endif

  always_comb begin
    for (int unsigned n = 0; n < 4; n++)
      pend[n] = (cnt[n] != '0);
    eligible = pend & ~mask;
    valid    = |eligible;
  end

  // Ascending scan: the last eligible line seen is the highest-priority one.
  always_comb begin
    sel = '0;
    for (int unsigned n = 0; n < 4; n++)
      if (eligible[n])
        sel = n[1:0];
  end

  always_comb begin
    y0 = valid ? sel[1] : 1'b0;
    y1 = valid ? sel[0] : 1'b0;
  end

  always_comb begin
    rise = {i3, i2, i1, i0} & ~in_q;
    for (int unsigned n = 0; n < 4; n++)
      dec[n] = ack && valid && (sel == n[1:0]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      in_q <= '1;
      ovf  <= '0;
      for (int unsigned n = 0; n < 4; n++)
        cnt[n] <= '0;
    end else begin
      in_q <= {i3, i2, i1, i0};
      for (int unsigned n = 0; n < 4; n++) begin
        if (rise[n] && !dec[n]) begin
          if (cnt[n] != CMAX)
            cnt[n] <= cnt[n] + 1'b1;
          else
            ovf[n] <= 1'b1;
        end else if (!rise[n] && dec[n]) begin
          cnt[n] <= cnt[n] - 1'b1;
        end
      end
    end
  end

endmodule
